multicycle_control_unit: RTL and testbench
==========================================

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 The block SHALL expose parameter MEM_HANDSHAKE, default 1: 1 = memory states wait for busReady, 0 = busReady ignored and treated as 1.
REQ-002 The block SHALL expose parameter CNT_W, default 32: width of the retired-instruction counter.
REQ-003 The block SHALL have ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- instrCode  in  32  current instruction, held stable by the datapath from DECODE to retire.
- busReady  in  1  data-memory access complete.
- pcEn  out  1  PC register update enable.
- regFileWe  out  1  register-file write enable.
- aluSrcMuxSel  out  1  0 = rs2, 1 = immediate.
- aluControl  out  4  ALU operation {funct7[5], funct3}; ADD = 4'b0000.
- rfWdSrcMuxSel  out  3  write-back source: 0 ALU, 1 bus rdata, 2 imm (LUI), 3 PC+imm (AUIPC), 4 PC+4.
- busWe  out  1  data-memory write strobe.
- busRe  out  1  data-memory read strobe.
- branch  out  1  PC takes PC+imm when ALU compare is true.
- jal  out  1  PC takes PC+imm.
- jalr  out  1  PC takes rs1+imm.
- illegalInstr  out  1  unsupported opcode pulse.
- instRetired  out  CNT_W  retired-instruction count.

Function
REQ-004 The block SHALL decode opcodes R 0110011, I 0010011, L 0000011, S 0100011, B 1100011, LU 0110111, AU 0010111, J 1101111, JL 1100111.
REQ-005 The block SHALL implement the Moore FSM states FETCH, DECODE, R_EXE, I_EXE, B_EXE, LU_EXE, AU_EXE, J_EXE, JL_EXE, S_EXE, S_MEM, L_EXE, L_MEM, L_WB.
REQ-006 Transitions SHALL be: FETCH -> DECODE; DECODE -> <type>_EXE per opcode, or -> FETCH on an illegal opcode; every single-step EXE state -> FETCH.
REQ-007 Memory-path transitions SHALL be: S_EXE -> S_MEM; L_EXE -> L_MEM; L_MEM -> L_WB; L_WB -> FETCH; S_MEM -> FETCH.
REQ-008 S_MEM and L_MEM SHALL hold while MEM_HANDSHAKE = 1 and busReady = 0; each extra wait adds one cycle.
REQ-009 Zero-wait latency SHALL be 3 cycles for R/I/B/LU/AU/J/JL, 4 cycles for S, 5 cycles for L, and 2 cycles for an illegal opcode.
REQ-010 pcEn SHALL be 1 only in the final state of each instruction: the state that exits to FETCH, including DECODE on an illegal opcode, and S_MEM/L_WB only on their exit cycle.
REQ-011 regFileWe SHALL be 1 only in R_EXE, I_EXE, LU_EXE, AU_EXE, J_EXE, JL_EXE and L_WB.
REQ-012 rfWdSrcMuxSel SHALL be 0 in R/I, 1 in L_WB, 2 in LU, 3 in AU, 4 in J/JL, and 0 elsewhere.
REQ-013 aluSrcMuxSel SHALL be 1 in I, S and L states and JL_EXE, and 0 elsewhere.
REQ-014 aluControl SHALL be {instrCode[30], instrCode[14:12]} for R.
REQ-015 aluControl SHALL be 4'b1101 for I when {instrCode[30], funct3} = 1101 (SRAI), else {0, funct3}.
REQ-016 aluControl SHALL be {0, funct3} for B, and ADD for all other states.
REQ-017 busWe SHALL be 1 throughout S_MEM, and busRe SHALL be 1 throughout L_MEM; both SHALL be 0 elsewhere.
REQ-018 branch SHALL be 1 only in B_EXE, jal only in J_EXE, and jalr only in JL_EXE.
REQ-019 illegalInstr SHALL pulse for exactly the DECODE cycle of an unsupported opcode, with no register or memory write.
REQ-020 instRetired SHALL increment by 1 on every cycle with pcEn = 1, wrap modulo 2^CNT_W, and count illegal instructions.
REQ-021 All outputs SHALL be registered-state decodes, with no combinational path from busReady to pcEn except in S_MEM/L_MEM exit.

Reset
REQ-022 reset = 1 on a rising clk edge SHALL force the state to FETCH and instRetired to 0, overriding all other events, including mid-instruction and mid-wait.
REQ-023 In FETCH, every output SHALL be 0, aluControl SHALL be ADD and rfWdSrcMuxSel SHALL be 0.
REQ-024 An aborted store or load SHALL drop busWe/busRe the cycle after reset is sampled.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- ADD then SUB (R, funct7[5] = 1) -> aluControl 0000 then 1000, regFileWe for 1 cycle each, 3 cycles each, instRetired = 2.
- SRAI vs SRLI -> aluControl 1101 vs 0101, aluSrcMuxSel = 1.
- LW with busReady low for 3 cycles -> busRe high for 4 cycles, L_WB regFileWe with rfWdSrcMuxSel = 1, total 8 cycles.
- SW with MEM_HANDSHAKE = 0 and busReady tied to 0 -> busWe for 1 cycle, 4 cycles total, regFileWe never set.
- Opcode 1111111 -> illegalInstr pulse in the DECODE cycle, pcEn = 1, back in FETCH after 2 cycles.
- Reset asserted in L_MEM -> FETCH and all outputs 0 next cycle.
- CNT_W = 4: 16 instructions -> instRetired wraps to 0.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I control unit: a Moore FSM that sequences fetch, decode,
// execute, memory and write-back steps. It drives the datapath strobes and
// counts retired instructions.
module multicycle_control_unit #(
  parameter int MEM_HANDSHAKE = 1,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instrCode,
  input  logic             busReady,
  output logic             pcEn,
  output logic             regFileWe,
  output logic             aluSrcMuxSel,
  output logic [3:0]       aluControl,
  output logic [2:0]       rfWdSrcMuxSel,
  output logic             busWe,
  output logic             busRe,
  output logic             branch,
  output logic             jal,
  output logic             jalr,
  output logic             illegalInstr,
  output logic [CNT_W-1:0] instRetired
);

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_L  = 7'b0000011;
  localparam logic [6:0] OP_S  = 7'b0100011;
  localparam logic [6:0] OP_B  = 7'b1100011;
  localparam logic [6:0] OP_LU = 7'b0110111;
  localparam logic [6:0] OP_AU = 7'b0010111;
  localparam logic [6:0] OP_J  = 7'b1101111;
  localparam logic [6:0] OP_JL = 7'b1100111;

  localparam logic [3:0] ALU_ADD = 4'b0000;

  localparam logic [2:0] WD_ALU   = 3'd0;
  localparam logic [2:0] WD_RDATA = 3'd1;
  localparam logic [2:0] WD_IMM   = 3'd2;
  localparam logic [2:0] WD_AUIPC = 3'd3;
  localparam logic [2:0] WD_PC4   = 3'd4;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    R_EXE,
    I_EXE,
    B_EXE,
    LU_EXE,
    AU_EXE,
    J_EXE,
    JL_EXE,
    S_EXE,
    S_MEM,
    L_EXE,
    L_MEM,
    L_WB
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  state_t           w_decoded_state;
  logic             w_opcode_legal;
  logic             w_mem_ready;
  logic [6:0]       w_opcode;
  logic [2:0]       w_funct3;
  logic             w_funct7_5;
  logic [CNT_W-1:0] r_inst_retired;
  logic             w_unused_bits;

  assign w_opcode      = instrCode[6:0];
  assign w_funct3      = instrCode[14:12];
  assign w_funct7_5    = instrCode[30];
  assign w_unused_bits = &{1'b0, instrCode[31], instrCode[29:15], instrCode[11:7]};

  // Without a handshake the memory is assumed to complete in a single cycle.
  assign w_mem_ready = (MEM_HANDSHAKE != 0) ? busReady : 1'b1;

  // Map the opcode to its first execute state; FETCH marks an unsupported opcode.
  always_comb begin
    w_decoded_state = FETCH;
    case (w_opcode)
      OP_R:    w_decoded_state = R_EXE;
      OP_I:    w_decoded_state = I_EXE;
      OP_L:    w_decoded_state = L_EXE;
      OP_S:    w_decoded_state = S_EXE;
      OP_B:    w_decoded_state = B_EXE;
      OP_LU:   w_decoded_state = LU_EXE;
      OP_AU:   w_decoded_state = AU_EXE;
      OP_J:    w_decoded_state = J_EXE;
      OP_JL:   w_decoded_state = JL_EXE;
      default: w_decoded_state = FETCH;
    endcase
  end

  assign w_opcode_legal = (w_decoded_state != FETCH);

  // State register; reset aborts any instruction, including a pending memory wait.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= FETCH;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; memory states stall until the bus reports completion.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      FETCH:   w_state_next = DECODE;
      DECODE:  w_state_next = w_decoded_state;
      S_EXE:   w_state_next = S_MEM;
      S_MEM:   w_state_next = w_mem_ready ? FETCH : S_MEM;
      L_EXE:   w_state_next = L_MEM;
      L_MEM:   w_state_next = w_mem_ready ? L_WB : L_MEM;
      L_WB:    w_state_next = FETCH;
      default: w_state_next = FETCH;
    endcase
  end

  // Moore output decode; only the S_MEM exit looks at busReady.
  always_comb begin
    pcEn          = 1'b0;
    regFileWe     = 1'b0;
    aluSrcMuxSel  = 1'b0;
    aluControl    = ALU_ADD;
    rfWdSrcMuxSel = WD_ALU;
    busWe         = 1'b0;
    busRe         = 1'b0;
    branch        = 1'b0;
    jal           = 1'b0;
    jalr          = 1'b0;
    illegalInstr  = 1'b0;
    case (r_state)
      DECODE: begin
        if (!w_opcode_legal) begin
          pcEn         = 1'b1;
          illegalInstr = 1'b1;
        end
      end
      R_EXE: begin
        pcEn       = 1'b1;
        regFileWe  = 1'b1;
        aluControl = {w_funct7_5, w_funct3};
      end
      I_EXE: begin
        pcEn         = 1'b1;
        regFileWe    = 1'b1;
        aluSrcMuxSel = 1'b1;
        // Bit 30 is immediate data for everything except the SRAI encoding.
        aluControl   = (w_funct7_5 && (w_funct3 == 3'b101)) ? 4'b1101 : {1'b0, w_funct3};
      end
      B_EXE: begin
        pcEn       = 1'b1;
        branch     = 1'b1;
        aluControl = {1'b0, w_funct3};
      end
      LU_EXE: begin
        pcEn          = 1'b1;
        regFileWe     = 1'b1;
        rfWdSrcMuxSel = WD_IMM;
      end
      AU_EXE: begin
        pcEn          = 1'b1;
        regFileWe     = 1'b1;
        rfWdSrcMuxSel = WD_AUIPC;
      end
      J_EXE: begin
        pcEn          = 1'b1;
        regFileWe     = 1'b1;
        rfWdSrcMuxSel = WD_PC4;
        jal           = 1'b1;
      end
      JL_EXE: begin
        pcEn          = 1'b1;
        regFileWe     = 1'b1;
        aluSrcMuxSel  = 1'b1;
        rfWdSrcMuxSel = WD_PC4;
        jalr          = 1'b1;
      end
      S_EXE: begin
        aluSrcMuxSel = 1'b1;
      end
      S_MEM: begin
        aluSrcMuxSel = 1'b1;
        busWe        = 1'b1;
        pcEn         = w_mem_ready;
      end
      L_EXE: begin
        aluSrcMuxSel = 1'b1;
      end
      L_MEM: begin
        aluSrcMuxSel = 1'b1;
        busRe        = 1'b1;
      end
      L_WB: begin
        pcEn          = 1'b1;
        regFileWe     = 1'b1;
        aluSrcMuxSel  = 1'b1;
        rfWdSrcMuxSel = WD_RDATA;
      end
      default: begin
        pcEn = 1'b0;
      end
    endcase
  end

  // Retired-instruction counter; every pcEn cycle retires exactly one instruction.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_inst_retired <= '0;
    end else if (pcEn) begin
      r_inst_retired <= r_inst_retired + CNT_W'(1);
    end
  end

  assign instRetired = r_inst_retired;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: a default instance plus a
// no-handshake, 4-bit-counter instance for the store and wrap scenarios.
module tb_multicycle_control_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] I_ADD   = 32'h003100B3;
  localparam logic [31:0] I_SUB   = 32'h403100B3;
  localparam logic [31:0] I_SRAI  = 32'h40315093;
  localparam logic [31:0] I_SRLI  = 32'h00315093;
  localparam logic [31:0] I_ADDI  = 32'h40010093;
  localparam logic [31:0] I_LW    = 32'h00012083;
  localparam logic [31:0] I_SW    = 32'h00312023;
  localparam logic [31:0] I_BNE   = 32'h40311063;
  localparam logic [31:0] I_LUI   = 32'h000010B7;
  localparam logic [31:0] I_AUIPC = 32'h00001097;
  localparam logic [31:0] I_JAL   = 32'h0000006F;
  localparam logic [31:0] I_JALR  = 32'h000100E7;
  localparam logic [31:0] I_ILL   = 32'h0000007F;

  // Default instance
  logic        reset, busReady;
  logic [31:0] instrCode;
  logic        pcEn, regFileWe, aluSrcMuxSel, busWe, busRe, branch, jal, jalr, illegalInstr;
  logic [3:0]  aluControl;
  logic [2:0]  rfWdSrcMuxSel;
  logic [31:0] instRetired;

  // No-handshake, 4-bit-counter instance
  logic        reset2;
  logic [31:0] instr2;
  logic        pcEn2, regFileWe2, aluSrcMuxSel2, busWe2, busRe2, branch2, jal2, jalr2, illegalInstr2;
  logic [3:0]  aluControl2;
  logic [2:0]  rfWdSrcMuxSel2;
  logic [3:0]  instRetired2;

  multicycle_control_unit dut (
    .clk(clk), .reset(reset), .instrCode(instrCode), .busReady(busReady),
    .pcEn(pcEn), .regFileWe(regFileWe), .aluSrcMuxSel(aluSrcMuxSel),
    .aluControl(aluControl), .rfWdSrcMuxSel(rfWdSrcMuxSel), .busWe(busWe),
    .busRe(busRe), .branch(branch), .jal(jal), .jalr(jalr),
    .illegalInstr(illegalInstr), .instRetired(instRetired)
  );

  multicycle_control_unit #(.MEM_HANDSHAKE(0), .CNT_W(4)) dut2 (
    .clk(clk), .reset(reset2), .instrCode(instr2), .busReady(1'b0),
    .pcEn(pcEn2), .regFileWe(regFileWe2), .aluSrcMuxSel(aluSrcMuxSel2),
    .aluControl(aluControl2), .rfWdSrcMuxSel(rfWdSrcMuxSel2), .busWe(busWe2),
    .busRe(busRe2), .branch(branch2), .jal(jal2), .jalr(jalr2),
    .illegalInstr(illegalInstr2), .instRetired(instRetired2)
  );

  // Packed output snapshot: {pcEn,we,aluSrc,aluCtl[3:0],wdSel[2:0],busWe,busRe,branch,jal,jalr,illegal}
  logic [15:0] o1, o2;
  assign o1 = {pcEn, regFileWe, aluSrcMuxSel, aluControl, rfWdSrcMuxSel,
               busWe, busRe, branch, jal, jalr, illegalInstr};
  assign o2 = {pcEn2, regFileWe2, aluSrcMuxSel2, aluControl2, rfWdSrcMuxSel2,
               busWe2, busRe2, branch2, jal2, jalr2, illegalInstr2};

  int tests_run    = 0;
  int tests_failed = 0;

  function automatic logic [15:0] ev(input logic pc, input logic we, input logic as,
                                     input logic [3:0] alu, input logic [2:0] wd,
                                     input logic bw, input logic br, input logic b,
                                     input logic j, input logic jr, input logic ill);
    return {pc, we, as, alu, wd, bw, br, b, j, jr, ill};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    tests_run++;
    if (o1 !== 16'h0000) begin
      tests_failed++;
      $display("FAIL reset_outputs got %h expected %h", o1, 16'h0000);
    end
    tests_run++;
    if (instRetired !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_count got %0d expected 0", instRetired);
    end
    tests_run++;
    if (o2 !== 16'h0000 || instRetired2 !== 4'd0) begin
      tests_failed++;
      $display("FAIL reset_dut2 got %h/%0d expected 0000/0", o2, instRetired2);
    end
    $display("[TB] reset state checked");
  endtask

  // Run single-step instructions through the default instance; exe[] is the EXE-state snapshot.
  task automatic test_r_type;
    logic [31:0] prog [2];
    logic [15:0] exe  [2];
    logic [15:0] exp_o;
    prog[0] = I_ADD; exe[0] = ev(1, 1, 0, 4'b0000, 3'd0, 0, 0, 0, 0, 0, 0);
    prog[1] = I_SUB; exe[1] = ev(1, 1, 0, 4'b1000, 3'd0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      instrCode = prog[i];
      for (int c = 0; c < 3; c++) begin
        exp_o = (c == 2) ? exe[i] : 16'h0000;
        tests_run++;
        if (o1 !== exp_o) begin
          tests_failed++;
          $display("FAIL r_type[%0d] cycle %0d got %h expected %h", i, c, o1, exp_o);
        end
        tick();
      end
      $display("[TB] R instr %h retired, count %0d", prog[i], instRetired);
    end
    tests_run++;
    if (o1 !== 16'h0000 || instRetired !== 32'd2) begin
      tests_failed++;
      $display("FAIL r_type_end got %h/%0d expected 0000/2", o1, instRetired);
    end
  endtask

  task automatic test_i_shift;
    logic [31:0] prog [3];
    logic [15:0] exe  [3];
    logic [15:0] exp_o;
    prog[0] = I_SRAI; exe[0] = ev(1, 1, 1, 4'b1101, 3'd0, 0, 0, 0, 0, 0, 0);
    prog[1] = I_SRLI; exe[1] = ev(1, 1, 1, 4'b0101, 3'd0, 0, 0, 0, 0, 0, 0);
    prog[2] = I_ADDI; exe[2] = ev(1, 1, 1, 4'b0000, 3'd0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      instrCode = prog[i];
      for (int c = 0; c < 3; c++) begin
        exp_o = (c == 2) ? exe[i] : 16'h0000;
        tests_run++;
        if (o1 !== exp_o) begin
          tests_failed++;
          $display("FAIL i_type[%0d] cycle %0d got %h expected %h", i, c, o1, exp_o);
        end
        tick();
      end
      $display("[TB] I instr %h retired, count %0d", prog[i], instRetired);
    end
    tests_run++;
    if (instRetired !== 32'd5) begin
      tests_failed++;
      $display("FAIL i_type_count got %0d expected 5", instRetired);
    end
  endtask

  task automatic test_other_types;
    logic [31:0] prog [5];
    logic [15:0] exe  [5];
    logic [15:0] exp_o;
    prog[0] = I_LUI;   exe[0] = ev(1, 1, 0, 4'b0000, 3'd2, 0, 0, 0, 0, 0, 0);
    prog[1] = I_AUIPC; exe[1] = ev(1, 1, 0, 4'b0000, 3'd3, 0, 0, 0, 0, 0, 0);
    prog[2] = I_JAL;   exe[2] = ev(1, 1, 0, 4'b0000, 3'd4, 0, 0, 0, 1, 0, 0);
    prog[3] = I_JALR;  exe[3] = ev(1, 1, 1, 4'b0000, 3'd4, 0, 0, 0, 0, 1, 0);
    prog[4] = I_BNE;   exe[4] = ev(1, 0, 0, 4'b0001, 3'd0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      instrCode = prog[i];
      for (int c = 0; c < 3; c++) begin
        exp_o = (c == 2) ? exe[i] : 16'h0000;
        tests_run++;
        if (o1 !== exp_o) begin
          tests_failed++;
          $display("FAIL other[%0d] cycle %0d got %h expected %h", i, c, o1, exp_o);
        end
        tick();
      end
      $display("[TB] instr %h retired, count %0d", prog[i], instRetired);
    end
    tests_run++;
    if (instRetired !== 32'd10) begin
      tests_failed++;
      $display("FAIL other_count got %0d expected 10", instRetired);
    end
  endtask

  task automatic test_load_wait;
    logic [15:0] exp_o;
    instrCode = I_LW;
    for (int c = 0; c < 8; c++) begin
      busReady = (c >= 3 && c <= 5) ? 1'b0 : 1'b1;
      if (c < 2)       exp_o = 16'h0000;
      else if (c == 2) exp_o = ev(0, 0, 1, 4'b0000, 3'd0, 0, 0, 0, 0, 0, 0);
      else if (c < 7)  exp_o = ev(0, 0, 1, 4'b0000, 3'd0, 0, 1, 0, 0, 0, 0);
      else             exp_o = ev(1, 1, 1, 4'b0000, 3'd1, 0, 0, 0, 0, 0, 0);
      tests_run++;
      if (o1 !== exp_o) begin
        tests_failed++;
        $display("FAIL load_wait cycle %0d got %h expected %h", c, o1, exp_o);
      end
      tick();
    end
    busReady = 1'b1;
    tests_run++;
    if (o1 !== 16'h0000 || instRetired !== 32'd11) begin
      tests_failed++;
      $display("FAIL load_end got %h/%0d expected 0000/11", o1, instRetired);
    end
    $display("[TB] LW with 3 wait cycles retired, count %0d", instRetired);
  endtask

  task automatic test_illegal;
    instrCode = I_ILL;
    tests_run++;
    if (o1 !== 16'h0000) begin
      tests_failed++;
      $display("FAIL illegal_fetch got %h expected 0000", o1);
    end
    tick();
    tests_run++;
    if (o1 !== ev(1, 0, 0, 4'b0000, 3'd0, 0, 0, 0, 0, 0, 1)) begin
      tests_failed++;
      $display("FAIL illegal_decode got %h expected %h", o1, ev(1, 0, 0, 4'b0000, 3'd0, 0, 0, 0, 0, 0, 1));
    end
    tick();
    tests_run++;
    if (o1 !== 16'h0000 || instRetired !== 32'd12) begin
      tests_failed++;
      $display("FAIL illegal_end got %h/%0d expected 0000/12", o1, instRetired);
    end
    $display("[TB] illegal opcode retired, count %0d", instRetired);
  endtask

  task automatic test_reset_mid_load;
    instrCode = I_LW;
    busReady  = 1'b0;
    tick();
    tick();
    tick();
    tests_run++;
    if (o1 !== ev(0, 0, 1, 4'b0000, 3'd0, 0, 1, 0, 0, 0, 0)) begin
      tests_failed++;
      $display("FAIL mid_load_wait got %h expected %h", o1, ev(0, 0, 1, 4'b0000, 3'd0, 0, 1, 0, 0, 0, 0));
    end
    reset = 1'b1;
    tick();
    reset    = 1'b0;
    busReady = 1'b1;
    tests_run++;
    if (o1 !== 16'h0000 || instRetired !== 32'd0) begin
      tests_failed++;
      $display("FAIL mid_load_reset got %h/%0d expected 0000/0", o1, instRetired);
    end
    $display("[TB] LW aborted by reset in L_MEM");
  endtask

  task automatic test_store_nohs;
    logic [15:0] exp_o;
    reset2 = 1'b0;
    instr2 = I_SW;
    for (int c = 0; c < 4; c++) begin
      if (c < 2)       exp_o = 16'h0000;
      else if (c == 2) exp_o = ev(0, 0, 1, 4'b0000, 3'd0, 0, 0, 0, 0, 0, 0);
      else             exp_o = ev(1, 0, 1, 4'b0000, 3'd0, 1, 0, 0, 0, 0, 0);
      tests_run++;
      if (o2 !== exp_o) begin
        tests_failed++;
        $display("FAIL store_nohs cycle %0d got %h expected %h", c, o2, exp_o);
      end
      tick();
    end
    tests_run++;
    if (o2 !== 16'h0000 || instRetired2 !== 4'd1) begin
      tests_failed++;
      $display("FAIL store_end got %h/%0d expected 0000/1", o2, instRetired2);
    end
    $display("[TB] SW without handshake retired, count %0d", instRetired2);
  endtask

  task automatic test_wrap;
    reset2 = 1'b1;
    tick();
    reset2 = 1'b0;
    tests_run++;
    if (instRetired2 !== 4'd0) begin
      tests_failed++;
      $display("FAIL wrap_start got %0d expected 0", instRetired2);
    end
    for (int i = 0; i < 16; i++) begin
      instr2 = i[0] ? I_ILL : I_ADD;
      for (int c = 0; c < (i[0] ? 2 : 3); c++) tick();
      if (i == 7 || i == 14) begin
        tests_run++;
        if (instRetired2 !== 4'(i + 1)) begin
          tests_failed++;
          $display("FAIL wrap_mid[%0d] got %0d expected %0d", i, instRetired2, i + 1);
        end
      end
      $display("[TB] dut2 instr %0d retired, count %0d", i, instRetired2);
    end
    tests_run++;
    if (instRetired2 !== 4'd0 || o2 !== 16'h0000) begin
      tests_failed++;
      $display("FAIL wrap_end got %0d/%h expected 0/0000", instRetired2, o2);
    end
  endtask

  initial begin
    reset     = 1'b1;
    reset2    = 1'b1;
    busReady  = 1'b1;
    instrCode = 32'h0;
    instr2    = 32'h0;
    tick();
    tick();
    reset = 1'b0;
    test_reset();
    test_r_type();
    test_i_shift();
    test_other_types();
    test_load_wait();
    test_illegal();
    test_reset_mid_load();
    test_store_nohs();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
